// File: rtl/max_pool_2x2_if.sv
// Sample stream into the 2x2 max-pool stage and the pooled stream out of it.
interface max_pool_2x2_if #(
    parameter int unsigned DATA_W = 25,
    parameter int unsigned MAP_W  = 26,
    parameter int unsigned MAP_H  = 26
);
    localparam int unsigned CNT_W = $clog2(MAP_W * MAP_H / 4 + 1);

    logic                     start_conv;
    logic signed [DATA_W-1:0] in;
    logic                     in_valid;
    logic signed [DATA_W-1:0] out;
    logic                     out_valid;
    logic                     frame_done;
    logic [CNT_W-1:0]         pool_cnt;

    // Upstream (ReLU stage / bench) side.
    modport master (
        output start_conv, in, in_valid,
        input  out, out_valid, frame_done, pool_cnt
    );

    // Pooling block side.
    modport slave (
        input  start_conv, in, in_valid,
        output out, out_valid, frame_done, pool_cnt
    );
endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a raster-ordered feature map.
// Even rows store pairwise maxima in a half-width line buffer; odd rows
// combine them with their own pairwise maxima to emit one pooled sample.
module max_pool_2x2 #(
    parameter int unsigned DATA_W = 25,
    parameter int unsigned MAP_W  = 26,
    parameter int unsigned MAP_H  = 26
) (
    input  logic           clk,
    input  logic           rst_n,
    max_pool_2x2_if.slave  bus
);
    localparam int unsigned HALF_W = MAP_W / 2;
    localparam int unsigned COL_W  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int unsigned ROW_W  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int unsigned IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int unsigned CNT_W  = $clog2(MAP_W * MAP_H / 4 + 1);

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     frame_done_q, frame_done_d;
    logic [CNT_W-1:0]         pool_cnt_q, pool_cnt_d;

    logic signed [DATA_W-1:0] linebuf_q [HALF_W];
    logic                     lb_we;
    logic [IDX_W-1:0]         lb_idx;
    logic signed [DATA_W-1:0] lb_rd;
    logic signed [DATA_W-1:0] pmax;
    logic signed [DATA_W-1:0] win_max;
    logic                     last_col;
    logic                     last_row;

    // Datapath helpers: pair maximum, window maximum, position flags.
    always_comb begin
        lb_idx   = IDX_W'(col_q >> 1);
        lb_rd    = linebuf_q[lb_idx];
        pmax     = (bus.in > hold_q) ? bus.in : hold_q;
        win_max  = (lb_rd > pmax) ? lb_rd : pmax;
        last_col = (col_q == COL_W'(MAP_W - 1));
        last_row = (row_q == ROW_W'(MAP_H - 1));
    end

    // Next-state: position counters, hold register, output and pool count.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        pool_cnt_d   = pool_cnt_q;
        lb_we        = 1'b0;

        if (!bus.start_conv) begin
            col_d      = '0;
            row_d      = '0;
            pool_cnt_d = '0;
        end else if (bus.in_valid) begin
            // First sample of a frame restarts the pooled-sample count.
            if ((row_q == '0) && (col_q == '0)) begin
                pool_cnt_d = '0;
            end

            if (!col_q[0]) begin
                hold_d = bus.in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_d       = win_max;
                out_valid_d = 1'b1;
                pool_cnt_d  = pool_cnt_q + CNT_W'(1);
            end

            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pool_cnt_q   <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            pool_cnt_q   <= pool_cnt_d;
        end
    end

    // Line buffer of even-row pair maxima; contents need no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= pmax;
        end
    end

    assign bus.out        = out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pool_cnt   = pool_cnt_q;
endmodule
